cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 135 +++++++++++++
 tb/tb_cache_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Direct-mapped, write-back / write-allocate cache: 16 one-word lines in front of a
// 256-word backing memory, sequenced by an IDLE/LOOKUP/WRITEBACK/ALLOCATE FSM.
module cache_controller (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        read,
  input  logic        write,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        miss,
  output logic        spaceAlreadyTakenByAnotherBlock
);

  localparam int LINES     = 16;
  localparam int MEM_WORDS = 256;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOOKUP    = 2'd1;
  localparam logic [1:0] WRITEBACK = 2'd2;
  localparam logic [1:0] ALLOCATE  = 2'd3;

  logic [1:0]       state;

  // Captured request; byte-offset bits are never stored.
  logic [31:2]      req_addr;
  logic [31:0]      req_data;
  logic             req_read;

  logic [LINES-1:0] line_valid;
  logic [LINES-1:0] line_dirty;
  logic [25:0]      line_tag  [LINES];
  logic [31:0]      line_data [LINES];
  logic [31:0]      mem       [MEM_WORDS];

  logic [3:0]       req_index;
  logic [25:0]      req_tag;
  logic [7:0]       mem_addr;
  logic [7:0]       wb_addr;
  logic             line_hit;
  logic             line_dirty_victim;
  logic             unused_addr_bits;

  assign req_index         = req_addr[5:2];
  assign req_tag           = req_addr[31:6];
  assign mem_addr          = req_addr[9:2];
  // The victim's home word is rebuilt from its own tag, not the request's.
  assign wb_addr           = {line_tag[req_index][3:0], req_index};
  assign line_hit          = line_valid[req_index] && (line_tag[req_index] == req_tag);
  assign line_dirty_victim = line_valid[req_index] && line_dirty[req_index];
  assign unused_addr_bits  = &{1'b0, address[1:0]};

  // NOTE: every register below is assigned with <= so all state updates see the
  // values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state                           <= IDLE;
      req_addr                        <= '0;
      req_data                        <= '0;
      req_read                        <= 1'b0;
      line_valid                      <= '0;
      line_dirty                      <= '0;
      read_data                       <= '0;
      hit                             <= 1'b0;
      miss                            <= 1'b0;
      spaceAlreadyTakenByAnotherBlock <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (read || write) begin
            req_addr <= address[31:2];
            req_data <= write_data;
            req_read <= read;
            state    <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (line_hit) begin
            hit                             <= 1'b1;
            miss                            <= 1'b0;
            spaceAlreadyTakenByAnotherBlock <= 1'b0;
            if (req_read) begin
              read_data <= line_data[req_index];
            end else begin
              line_data[req_index]  <= req_data;
              line_dirty[req_index] <= 1'b1;
            end
            state <= IDLE;
          end else begin
            hit                             <= 1'b0;
            miss                            <= 1'b1;
            spaceAlreadyTakenByAnotherBlock <= line_valid[req_index];
            state <= line_dirty_victim ? WRITEBACK : ALLOCATE;
          end
        end

        WRITEBACK: begin
          line_dirty[req_index] <= 1'b0;
          state                 <= ALLOCATE;
        end

        ALLOCATE: begin
          line_valid[req_index] <= 1'b1;
          line_tag[req_index]   <= req_tag;
          if (req_read) begin
            line_data[req_index]  <= mem[mem_addr];
            line_dirty[req_index] <= 1'b0;
            read_data             <= mem[mem_addr];
          end else begin
            line_data[req_index]  <= req_data;
            line_dirty[req_index] <= 1'b1;
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the backing memory is architecturally cleared by reset, so it is a reset
  // register file; line tag/data arrays need no reset because valid gates them.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (state == WRITEBACK) begin
      mem[wb_addr] <= line_data[req_index];
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: a reference cache model predicts status,
// load data and latency for each request; results are compared at completion.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        read;
  logic        write;
  logic [31:0] read_data;
  logic        hit;
  logic        miss;
  logic        conflict;

  cache_controller dut (
    .clk                             (clk),
    .rst_b                           (rst_b),
    .address                         (address),
    .write_data                      (write_data),
    .read                            (read),
    .write                           (write),
    .read_data                       (read_data),
    .hit                             (hit),
    .miss                            (miss),
    .spaceAlreadyTakenByAnotherBlock (conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic        miss;
    logic        conflict;
    logic [31:0] rd;
    logic [31:0] pre_rd;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic        m_valid [16];
  logic        m_dirty [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  logic [31:0] m_mem   [256];
  logic [31:0] m_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    m_rd = '0;
  endtask

  task automatic model_op(input logic is_read, input logic [31:0] a,
                          input logic [31:0] wd, output exp_t e);
    logic [3:0]  idx;
    logic [25:0] tg;
    logic [7:0]  victim;
    idx      = a[5:2];
    tg       = a[31:6];
    e.pre_rd = m_rd;
    if (m_valid[idx] && m_tag[idx] == tg) begin
      e.hit = 1'b1; e.miss = 1'b0; e.conflict = 1'b0; e.lat = 1;
      if (is_read) m_rd = m_data[idx];
      else begin
        m_data[idx]  = wd;
        m_dirty[idx] = 1'b1;
      end
    end else begin
      e.hit = 1'b0; e.miss = 1'b1; e.conflict = m_valid[idx]; e.lat = 2;
      if (m_valid[idx] && m_dirty[idx]) begin
        victim        = {m_tag[idx][3:0], idx};
        m_mem[victim] = m_data[idx];
        e.lat         = 3;
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      if (is_read) begin
        m_data[idx]  = m_mem[a[9:2]];
        m_dirty[idx] = 1'b0;
        m_rd         = m_data[idx];
      end else begin
        m_data[idx]  = wd;
        m_dirty[idx] = 1'b1;
      end
    end
    e.rd = m_rd;
  endtask

  // Called at a falling edge; returns at the falling edge after completion.
  task automatic do_op(input string tag, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    read       = rd;
    write      = wr;
    address    = a;
    write_data = wd;
    model_op(rd, a, wd, e);
    sb.push_back(e);
    @(negedge clk);
    read  = 1'b0;
    write = 1'b0;
    repeat (e.lat - 1) @(negedge clk);
    check({tag, "/rd_before_done"}, read_data, e.pre_rd);
    @(negedge clk);
    e = sb.pop_front();
    check({tag, "/hit"},      {31'b0, hit},      {31'b0, e.hit});
    check({tag, "/miss"},     {31'b0, miss},     {31'b0, e.miss});
    check({tag, "/conflict"}, {31'b0, conflict}, {31'b0, e.conflict});
    check({tag, "/read_data"}, read_data, e.rd);
  endtask

  initial begin
    rst_b = 1'b1; read = 1'b0; write = 1'b0; address = '0; write_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    check("reset/hit",       {31'b0, hit},      32'd0);
    check("reset/miss",      {31'b0, miss},     32'd0);
    check("reset/conflict",  {31'b0, conflict}, 32'd0);
    check("reset/read_data", read_data,         32'd0);

    do_op("rd_0x0",        1, 0, 32'h0000_0000, 32'h0);
    do_op("wr_0x4",        0, 1, 32'h0000_0004, 32'hCAFE_BABE);
    do_op("rd_0x4",        1, 0, 32'h0000_0004, 32'h0);
    check("rd_0x4/value", read_data, 32'hCAFE_BABE);
    do_op("rd_0x8_a",      1, 0, 32'h0000_0008, 32'h0);
    do_op("rd_0x8_b",      1, 0, 32'h0000_0008, 32'h0);
    do_op("wr_0xC",        0, 1, 32'h0000_000C, 32'hDEAD_BEEF);
    do_op("rd_0x4C",       1, 0, 32'h0000_004C, 32'h0);
    do_op("rd_0xC",        1, 0, 32'h0000_000C, 32'h0);
    check("rd_0xC/value", read_data, 32'hDEAD_BEEF);
    do_op("wr_0x10",       0, 1, 32'h0000_0010, 32'h0000_0055);
    do_op("rdwr_0x10",     1, 1, 32'h0000_0010, 32'h0000_1234);
    do_op("rd_0x10",       1, 0, 32'h0000_0010, 32'h0);
    check("rd_0x10/value", read_data, 32'h0000_0055);
    do_op("wr_alias",      0, 1, 32'h1234_5678, 32'h0000_A5A5);
    do_op("rd_alias",      1, 0, 32'h0000_0278, 32'h0);
    check("rd_alias/value", read_data, 32'h0000_A5A5);

    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      int          kind;
      a    = 32'(($urandom_range(0, 1) << 20) | ($urandom_range(0, 3) << 6) |
                 ($urandom_range(0, 3) << 2));
      kind = $urandom_range(0, 2);
      do_op("rand", kind != 1, kind != 0, a, $urandom());
    end

    // Reset lands on the ALLOCATE edge of a clean read miss.
    address = 32'h0000_0020; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    @(negedge clk);
    check("abort/miss_seen", {31'b0, miss}, 32'd1);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    model_reset();
    check("abort/hit",       {31'b0, hit},      32'd0);
    check("abort/miss",      {31'b0, miss},     32'd0);
    check("abort/conflict",  {31'b0, conflict}, 32'd0);
    check("abort/read_data", read_data,         32'd0);
    do_op("abort_rd_0x20", 1, 0, 32'h0000_0020, 32'h0);
    do_op("post_rst_0xC",  1, 0, 32'h0000_000C, 32'h0);
    check("post_rst_0xC/value", read_data, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
